up_counter: RTL and testbench

- Free-running, parameterised up-counter, 8 bits by default, clocked on the rising edge of clk.
- Counts from 0 up to a configurable maximum, then wraps to 0.
- Provides status outputs: terminal-count flag, wrap pulse and a saturating wrap counter.
- Used as a timebase or sequence source; its count value feeds downstream display or trace logic.

---
 rtl/counter_pkg.sv | 28 ++
 rtl/sat_counter.sv | 21 ++
 rtl/up_counter.sv | 46 ++++
 tb/tb_up_counter.sv | 129 ++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared constants and next-count arithmetic for the up_counter timebase.
package counter_pkg;

    localparam int unsigned COUNT_WIDTH_DEF = 8;
    localparam int unsigned WRAP_WIDTH_DEF  = 8;

    // One bit wider than the widest supported count (32), so q + STEP cannot overflow.
    localparam int unsigned CALC_W = 33;

    typedef struct packed {
        logic              wrap;
        logic [CALC_W-1:0] value;
    } next_count_t;

    function automatic next_count_t next_count(
        input logic [CALC_W-1:0] q,
        input logic [CALC_W-1:0] step,
        input logic [CALC_W-1:0] max
    );
        next_count_t       r;
        logic [CALC_W-1:0] sum;
        sum     = q + step;
        r.wrap  = (sum > max);
        r.value = r.wrap ? (sum - max - CALC_W'(1)) : sum;
        return r;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts inc pulses and holds at all-ones.
module sat_counter
    import counter_pkg::*;
#(
    parameter int unsigned WRAPW = WRAP_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WRAPW-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WRAPW'(1);
        end
    end

endmodule

// File: rtl/up_counter.sv
// Free-running modulo-(MAX_VAL+1) up-counter with terminal-count, wrap pulse and wrap tally.
module up_counter
    import counter_pkg::*;
#(
    parameter int unsigned      WRAPW   = WRAP_WIDTH_DEF,
    parameter int unsigned      WIDTH   = COUNT_WIDTH_DEF,
    parameter logic [WIDTH-1:0] MAX_VAL = '1,
    parameter logic [WIDTH-1:0] STEP    = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic [WRAPW-1:0] wraps
);

    next_count_t nxt;

    always_comb begin
        nxt = next_count(CALC_W'(q), CALC_W'(STEP), CALC_W'(MAX_VAL));
    end

    // Count register and the one-cycle wrap pulse that accompanies the post-wrap value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q    <= '0;
            wrap <= 1'b0;
        end else begin
            q    <= WIDTH'(nxt.value);
            wrap <= nxt.wrap;
        end
    end

    assign tc = (q == MAX_VAL);

    sat_counter #(
        .WRAPW (WRAPW)
    ) u_wraps (
        .clk   (clk),
        .reset (reset),
        .inc   (nxt.wrap),
        .count (wraps)
    );

endmodule

// File: tb/tb_up_counter.sv
// Scoreboard bench for up_counter: three configurations checked against an arithmetic model.
module tb_up_counter;

    localparam int NDUT = 3;
    localparam int MX[NDUT]     = '{255, 9, 3};
    localparam int ST[NDUT]     = '{1, 3, 1};
    localparam int SATMAX[NDUT] = '{255, 255, 3};

    typedef struct {
        int q  [NDUT];
        int tc [NDUT];
        int wr [NDUT];
        int ws [NDUT];
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] q0, q1, q2;
    logic       tc0, tc1, tc2;
    logic       wr0, wr1, wr2;
    logic [7:0] ws0, ws1;
    logic [1:0] ws2;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   n = 0;

    always #5 clk = ~clk;

    up_counter u_def (
        .clk (clk), .reset (reset), .q (q0), .tc (tc0), .wrap (wr0), .wraps (ws0)
    );

    up_counter #(.MAX_VAL (8'd9), .STEP (8'd3)) u_m9 (
        .clk (clk), .reset (reset), .q (q1), .tc (tc1), .wrap (wr1), .wraps (ws1)
    );

    up_counter #(.MAX_VAL (8'd3), .WRAPW (2)) u_w2 (
        .clk (clk), .reset (reset), .q (q2), .tc (tc2), .wrap (wr2), .wraps (ws2)
    );

    // After n counting edges the count is n*STEP modulo MAX+1; wraps is how often that total passed MAX.
    function automatic exp_t model(input bit run, input int cnt);
        exp_t e;
        for (int d = 0; d < NDUT; d++) begin
            int span;
            int tot;
            int w;
            int wp;
            span = MX[d] + 1;
            tot  = cnt * ST[d];
            w    = tot / span;
            wp   = (cnt > 0) ? ((cnt - 1) * ST[d]) / span : 0;
            e.q[d]  = run ? tot % span : 0;
            e.ws[d] = run ? ((w > SATMAX[d]) ? SATMAX[d] : w) : 0;
            e.wr[d] = (run && cnt > 0 && w != wp) ? 1 : 0;
            e.tc[d] = (run && e.q[d] == MX[d]) ? 1 : 0;
        end
        return e;
    endfunction

    task automatic chk(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d time=%0t", nm, act, exp_v, $time);
        end
    endtask

    // One clock: the edge uses the current reset level, then reset is (re)driven mid-cycle.
    task automatic step(input bit nxt_rst);
        @(posedge clk);
        if (reset) n++;
        #2;
        reset = nxt_rst;
        if (!nxt_rst) n = 0;
        sb.push_back(model(nxt_rst, n));
    endtask

    // Monitor: every falling edge the DUTs present a value; compare with the oldest expectation.
    initial begin
        exp_t e;
        int   aq [NDUT];
        int   atc[NDUT];
        int   awr[NDUT];
        int   aws[NDUT];
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                aq  = '{int'(q0), int'(q1), int'(q2)};
                atc = '{int'(tc0), int'(tc1), int'(tc2)};
                awr = '{int'(wr0), int'(wr1), int'(wr2)};
                aws = '{int'(ws0), int'(ws1), int'(ws2)};
                for (int d = 0; d < NDUT; d++) begin
                    chk($sformatf("dut%0d.q", d),     aq[d],  e.q[d]);
                    chk($sformatf("dut%0d.tc", d),    atc[d], e.tc[d]);
                    chk($sformatf("dut%0d.wrap", d),  awr[d], e.wr[d]);
                    chk($sformatf("dut%0d.wraps", d), aws[d], e.ws[d]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        repeat (3 + $urandom_range(0, 3)) step(1'b0);
        repeat (300) step(1'b1);
        while ((n % 256) != 100) step(1'b1);
        repeat (2) step(1'b0);
        repeat (30) step(1'b1);
        for (int k = 0; k < 6; k++) begin
            repeat ($urandom_range(1, 400)) step(1'b1);
            repeat ($urandom_range(1, 3)) step(1'b0);
        end
        repeat (5) step(1'b1);
        repeat (4) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
